// File: rtl/gate_lab_pkg.sv
// Shared definitions for the gate lab sweep controller: FSM encoding and
// parameter limits.
package gate_lab_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SETTLE_MIN = 1;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long a stimulus vector is held
// before the GUT output is sampled.
module settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input combination into a gate under test, samples it after a
// settle time and compares against a golden output, keeping mismatch stats.
//
// state | meaning
// IDLE  | waiting for start; outputs hold
// APPLY | dut_a = vec, settle timer counting down
// CHECK | compare dut_y with exp_y, advance vec or finish
// DONE  | one-cycle done pulse
module gate_sweep_ctrl
  import gate_lab_pkg::*;
#(
  parameter int N_IN   = 1,
  parameter int SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] dut_a,
  input  logic            dut_y,
  input  logic            exp_y,
  output logic            busy,
  output logic            done,
  output logic            res_valid,
  output logic            res_pass,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            fail_seen,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int SETTLE_EFF = (SETTLE < SETTLE_MIN) ? SETTLE_MIN : SETTLE;
  localparam int TW = $clog2(SETTLE_EFF) + 1;
  localparam logic [TW-1:0]   RELOAD = TW'(SETTLE_EFF - 1);
  localparam logic [N_IN-1:0] LAST   = '1;

  state_t          state, state_nxt;
  logic [N_IN-1:0] vec;
  logic            t_load, t_en, t_zero;
  logic            sweep_init, check_fire, vec_inc;
  logic            pass_now;

  settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .en       (t_en),
    .load_val (RELOAD),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    t_load     = 1'b0;
    t_en       = 1'b0;
    sweep_init = 1'b0;
    check_fire = 1'b0;
    vec_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = APPLY;
          t_load     = 1'b1;
          sweep_init = 1'b1;
        end
      end
      APPLY: begin
        if (abort)
          state_nxt = IDLE;
        else if (t_zero)
          state_nxt = CHECK;
        else
          t_en = 1'b1;
      end
      CHECK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          check_fire = 1'b1;
          if (vec == LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = APPLY;
            t_load    = 1'b1;
            vec_inc   = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Case equality so an X/Z from the GUT is scored as a mismatch in simulation.
  assign pass_now = (dut_y === exp_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      vec            <= '0;
      res_valid      <= 1'b0;
      res_pass       <= 1'b0;
      mismatch_cnt   <= '0;
      fail_seen      <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      res_valid <= check_fire;
      if (sweep_init) begin
        vec          <= '0;
        mismatch_cnt <= '0;
        fail_seen    <= 1'b0;
      end
      if (vec_inc)
        vec <= vec + N_IN'(1);
      if (check_fire) begin
        res_pass <= pass_now;
        if (!pass_now) begin
          mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
          if (!fail_seen) begin
            fail_seen      <= 1'b1;
            first_fail_vec <= vec;
          end
        end
      end
    end
  end

  assign dut_a = vec;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl: GUT and golden model are random truth
// tables; expectations come from cycle arithmetic over the sweep schedule.
module tb_gate_sweep_ctrl;

  localparam int N = 3;
  localparam int S = 2;
  localparam int V = 1 << N;
  localparam int T = V * (S + 1);

  logic         clk = 1'b0;
  logic         rst, start, abort;
  logic         dut_y, exp_y;
  logic         busy, done, res_valid, res_pass, fail_seen;
  logic [N-1:0] dut_a, first_fail_vec;
  logic [N:0]   mismatch_cnt;
  logic [V-1:0] gut_tab, gold_tab;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign dut_y = gut_tab[dut_a];
  assign exp_y = gold_tab[dut_a];

  gate_sweep_ctrl #(.N_IN(N), .SETTLE(S)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .dut_a          (dut_a),
    .dut_y          (dut_y),
    .exp_y          (exp_y),
    .busy           (busy),
    .done           (done),
    .res_valid      (res_valid),
    .res_pass       (res_pass),
    .mismatch_cnt   (mismatch_cnt),
    .fail_seen      (fail_seen),
    .first_fail_vec (first_fail_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // c = edges since the start edge; a/r = abort/reset edge (0 = none);
  // fresh = a held start has just launched a new sweep.
  task automatic expect_at(input int c, input int a, input int r, input bit fresh);
    bit ab, rs;
    int cc, n, e_busy, e_done, e_rv, e_a, e_cnt, e_ff, e_fs;
    ab = (a > 0) && (c >= a);
    rs = (r > 0) && (c >= r);
    cc = ab ? a - 1 : c;
    n  = cc / (S + 1);
    if (n > V) n = V;
    e_a = cc / (S + 1);
    if (e_a > V - 1) e_a = V - 1;
    e_busy = (!ab && c <= T) ? 1 : 0;
    e_done = (!ab && c == T) ? 1 : 0;
    e_rv   = (!ab && c > 0 && c <= T && (c % (S + 1)) == 0) ? 1 : 0;
    e_cnt  = 0;
    e_ff   = 0;
    for (int k = 0; k < n; k++)
      if (gut_tab[k] != gold_tab[k]) begin
        if (e_cnt == 0) e_ff = k;
        e_cnt++;
      end
    e_fs = (e_cnt > 0) ? 1 : 0;
    if (fresh) begin
      e_busy = 1; e_done = 0; e_rv = 0; e_a = 0; e_cnt = 0; e_fs = 0;
    end
    if (rs) begin
      e_busy = 0; e_done = 0; e_rv = 0; e_a = 0; e_cnt = 0; e_fs = 0; e_ff = 0;
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("res_valid", res_valid, e_rv);
    chk("dut_a", dut_a, e_a);
    chk("mismatch_cnt", mismatch_cnt, e_cnt);
    chk("fail_seen", fail_seen, e_fs);
    if (e_fs == 1 || rs)
      chk("first_fail_vec", first_fail_vec, e_ff);
    if (e_rv == 1)
      chk("res_pass", res_pass, (gut_tab[c/(S+1)-1] == gold_tab[c/(S+1)-1]) ? 1 : 0);
    else if (rs)
      chk("res_pass_rst", res_pass, 0);
  endtask

  // Entered #1 after the start edge; walks the sweep one edge at a time.
  task automatic follow(input int a, input int r, input int sm, input bit hold);
    int last_c;
    last_c = hold ? T + 2 : T + 1;
    for (int c = 0; c <= last_c; c++) begin
      if (c > 0) begin
        @(negedge clk);
        abort = (c == a);
        rst   = (c == r);
        start = hold || (c == sm);
        @(posedge clk);
        #1;
      end
      expect_at(c, a, r, hold && (c == T + 2));
    end
  endtask

  task automatic sweep(input int a, input int r, input int sm, input bit hold);
    @(negedge clk);
    abort = 1'b0;
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = hold;
    follow(a, r, sm, hold);
    if (hold) begin
      start = 1'b0;
      follow(0, 0, 0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int mode;
    rst      = 1'b1;
    start    = 1'b1;
    abort    = 1'b0;
    gut_tab  = '0;
    gold_tab = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_pass", res_pass, 0);
    chk("rst_dut_a", dut_a, 0);
    chk("rst_mismatch_cnt", mismatch_cnt, 0);
    chk("rst_fail_seen", fail_seen, 0);
    chk("rst_first_fail_vec", first_fail_vec, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    gold_tab = V'($urandom);
    gut_tab  = gold_tab;
    sweep(0, 0, 0, 1'b0);
    gut_tab = ~gold_tab;
    sweep(0, 0, 0, 1'b0);
    gut_tab = gold_tab ^ V'($urandom);
    sweep(2 * (S + 1) + 1, 0, 0, 1'b0);
    sweep(0, 0, 0, 1'b0);
    sweep(0, 0, T / 2, 1'b0);
    sweep(0, T / 2 + 1, 0, 1'b0);
    sweep(0, 0, 0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      gold_tab = V'($urandom);
      gut_tab  = gold_tab ^ (V'($urandom) & V'($urandom));
      mode = $urandom_range(0, 4);
      case (mode)
        1:       sweep($urandom_range(1, T), 0, 0, 1'b0);
        2:       sweep(0, $urandom_range(1, T + 1), 0, 1'b0);
        3:       sweep(0, 0, $urandom_range(1, T), 1'b0);
        4:       sweep(0, 0, 0, 1'b1);
        default: sweep(0, 0, 0, 1'b0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
